// File: rtl/master_1.sv
// Single-shot bit-per-clock I2C-style write master: START, address, R/W, ACK slot,
// data byte, ACK slot, STOP, then parked until the next reset.
module master_1 #(
  parameter int IDLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RW,
  input  logic [6:0] addr_in,
  input  logic [7:0] data_in,
  output logic       i2c_sda,
  output logic       i2c_scl,
  output logic [3:0] dbg_state
);

  localparam int CW = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_CYCLES);

  // Each state names what the registered outputs are driving during that cycle.
  typedef enum logic [3:0] {
    IDLE, START, ADDR, RWBIT, ACK1, DATA, ACK2, STOP0, STOP1, DONE
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] idle_cnt, idle_d;
  logic [2:0]    addr_cnt, addr_cnt_d;
  logic [2:0]    data_cnt, data_cnt_d;
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    data_q, data_d;
  logic          rw_q, rw_d;
  logic          sda_q, sda_d;
  logic          scl_en, scl_en_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idle_cnt <= '0;
      addr_cnt <= '0;
      data_cnt <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rw_q     <= 1'b0;
      sda_q    <= 1'b1;
      scl_en   <= 1'b0;
    end else begin
      state    <= state_d;
      idle_cnt <= idle_d;
      addr_cnt <= addr_cnt_d;
      data_cnt <= data_cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rw_q     <= rw_d;
      sda_q    <= sda_d;
      scl_en   <= scl_en_d;
    end
  end

  always_comb begin
    state_d    = state;
    idle_d     = idle_cnt;
    addr_cnt_d = addr_cnt;
    data_cnt_d = data_cnt;
    addr_d     = addr_q;
    data_d     = data_q;
    rw_d       = rw_q;
    sda_d      = 1'b1;
    scl_en_d   = 1'b0;
    case (state)
      IDLE: begin
        if (idle_cnt == IDLE_LAST) begin
          state_d = START;
          sda_d   = 1'b0;
          addr_d  = addr_in;
          data_d  = data_in;
          rw_d    = RW;
        end else begin
          idle_d = idle_cnt + 1'b1;
        end
      end
      START: begin
        state_d    = ADDR;
        addr_cnt_d = 3'd6;
        sda_d      = addr_q[6];
        scl_en_d   = 1'b1;
      end
      ADDR: begin
        scl_en_d = 1'b1;
        if (addr_cnt == 3'd0) begin
          state_d = RWBIT;
          sda_d   = rw_q;
        end else begin
          addr_cnt_d = addr_cnt - 3'd1;
          sda_d      = addr_q[addr_cnt_d];
        end
      end
      RWBIT: begin
        state_d  = ACK1;
        scl_en_d = 1'b1;
      end
      ACK1: begin
        state_d    = DATA;
        data_cnt_d = 3'd7;
        sda_d      = rw_q | data_q[7];
        scl_en_d   = 1'b1;
      end
      DATA: begin
        scl_en_d = 1'b1;
        if (data_cnt == 3'd0) begin
          state_d = ACK2;
        end else begin
          data_cnt_d = data_cnt - 3'd1;
          // A read leaves the line released for the whole byte.
          sda_d      = rw_q | data_q[data_cnt_d];
        end
      end
      ACK2: begin
        state_d = STOP0;
        sda_d   = 1'b0;
      end
      STOP0:   state_d = STOP1;
      STOP1:   state_d = DONE;
      DONE:    state_d = DONE;
      default: begin
        state_d = IDLE;
        idle_d  = '0;
      end
    endcase
  end

  assign i2c_sda   = sda_q;
  assign i2c_scl   = scl_en ? ~clk : 1'b1;
  assign dbg_state = state;

endmodule

// File: tb/tb_master_1.sv
// Bench for master_1: per-cycle expected SDA/SCL pairs are queued from the bus
// schedule when a transaction starts, then popped and compared cycle by cycle.
module tb_master_1;

  logic       clk;
  logic       reset;
  logic       RW;
  logic [6:0] addr_in;
  logic [7:0] data_in;
  logic       i2c_sda;
  logic       i2c_scl;
  logic [3:0] dbg_state;

  logic [1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  master_1 #(.IDLE_CYCLES(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .RW        (RW),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .i2c_sda   (i2c_sda),
    .i2c_scl   (i2c_scl),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Expected {sda, scl} just after rising edge P<p>.
  function automatic logic [1:0] sched(input int p, input logic [6:0] a,
                                       input logic [7:0] d, input logic r);
    logic s;
    logic c;
    c = (p >= 4 && p <= 21) ? 1'b0 : 1'b1;
    if (p <= 2)                s = 1'b1;
    else if (p == 3)           s = 1'b0;
    else if (p <= 10)          s = a[10 - p];
    else if (p == 11)          s = r;
    else if (p == 12)          s = 1'b1;
    else if (p <= 20)          s = r ? 1'b1 : d[20 - p];
    else if (p == 21)          s = 1'b1;
    else if (p == 22)          s = 1'b0;
    else                       s = 1'b1;
    return {s, c};
  endfunction

  task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input logic r,
                         input int n, input bit change_in);
    logic [1:0] obs;
    logic [1:0] exp;
    logic       prev_scl;
    int         rises;
    RW      = r;
    addr_in = a;
    data_in = d;
    exp_q.delete();
    for (int p = 1; p <= n; p++) exp_q.push_back(sched(p, a, d, r));
    @(negedge clk);
    reset = 1'b0;
    rises = 0;
    for (int p = 1; p <= n; p++) begin
      @(posedge clk);
      #1;
      obs = {i2c_sda, i2c_scl};
      if (exp_q.size() == 0) begin
        check("queue_empty", 1, 0);
        exp = 2'b11;
      end else begin
        exp = exp_q.pop_front();
      end
      check($sformatf("bus_p%0d", p), obs, exp);
      if (p == 3 && change_in) begin
        addr_in = ~a;
        data_in = ~d;
        RW      = ~r;
      end
      prev_scl = i2c_scl;
      @(negedge clk);
      #1;
      check($sformatf("scl_high_neg_p%0d", p), i2c_scl, 1'b1);
      check($sformatf("sda_stable_p%0d", p), i2c_sda, obs[1]);
      if (!prev_scl && i2c_scl) rises++;
    end
    if (n >= 24) check("scl_rises", rises, 18);
  endtask

  initial begin
    reset   = 1'b1;
    RW      = 1'b0;
    addr_in = '0;
    data_in = '0;

    // Reset hold: bus released, SCL quiet.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_sda_pos", i2c_sda, 1'b1);
      check("rst_scl_pos", i2c_scl, 1'b1);
      @(negedge clk);
      #1;
      check("rst_scl_neg", i2c_scl, 1'b1);
    end

    // Basic write, then idle after STOP.
    run_txn(7'h55, 8'hA5, 1'b0, 27, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Read direction.
    run_txn(7'h2A, 8'hFF, 1'b1, 26, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Inputs changed after the latch point must not affect the frame.
    run_txn(7'h3C, 8'h96, 1'b0, 26, 1'b1);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    // Random frames.
    for (int k = 0; k < 3; k++) begin
      run_txn(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)),
              1'($urandom_range(0, 1)), 26, 1'($urandom_range(0, 1)));
      reset = 1'b1;
      repeat (2) @(posedge clk);
    end

    // Reset while data bit 3 (a zero) is on the line.
    run_txn(7'h55, 8'hA5, 1'b0, 17, 1'b0);
    check("pre_abort_sda", i2c_sda, 1'b0);
    reset = 1'b1;
    #1;
    check("abort_sda", i2c_sda, 1'b1);
    check("abort_scl", i2c_scl, 1'b1);
    @(posedge clk);
    #1;
    check("abort_sda_pos", i2c_sda, 1'b1);
    check("abort_scl_pos", i2c_scl, 1'b1);
    repeat (2) @(posedge clk);
    run_txn(7'h11, 8'h5A, 1'b0, 26, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
